fpu_result_buffer: RTL

Result-capture stage directly downstream of the single-precision FPU adder. Accepts each registered 32-bit result and its 4-bit status word, and queues them in a DEPTH-entry FIFO. Results are presented to the consumer through a valid/ready handshake. The block also keeps sticky cumulative exception flags and a count of results dropped because the FIFO was full.

---
 rtl/fpu_result_buffer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fpu_result_buffer.sv
// Result FIFO behind the FPU adder: show-ahead queue with sticky exception flags and a drop counter.
// Optional build macro FPU_RESBUF_STATS_EN adds saturating overflow/underflow push counters.
module fpu_result_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [31:0]                in_data,
  input  logic [3:0]                 in_status,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [3:0]                 out_status,
  output logic [$clog2(DEPTH):0]     level,
  output logic [2:0]                 acc_flags,
  input  logic                       flags_clr,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       lost
`ifdef FPU_RESBUF_STATS_EN
  ,
  output logic [15:0]                ovf_cnt,
  output logic [15:0]                unf_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [35:0]    mem_reg [DEPTH];
  logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]  level_reg, level_next;
  logic [2:0]     acc_flags_reg, acc_flags_next;
  logic           lost_reg, lost_next;
  logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
  logic           push, pop, drop;

  assign in_ready  = (level_reg != FULL_LVL);
  assign out_valid = (level_reg != '0);
  assign push      = in_valid && in_ready;
  assign drop      = in_valid && !in_ready;
  assign pop       = out_valid && out_ready;

  // Show-ahead head: the entry under the read pointer is always visible.
  assign out_data   = mem_reg[rd_ptr_reg][31:0];
  assign out_status = mem_reg[rd_ptr_reg][35:32];

  assign level     = level_reg;
  assign acc_flags = acc_flags_reg;
  assign lost      = lost_reg;
  assign drop_cnt  = drop_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          mem_reg[gi] <= {in_status, in_data};
        end
      end
    end
  endgenerate

  always_comb begin
    level_next = level_reg;
    if (push && !pop) begin
      level_next = level_reg + LW'(1);
    end else if (pop && !push) begin
      level_next = level_reg - LW'(1);
    end

    // A clear coinciding with a new event still keeps that event's contribution.
    acc_flags_next = flags_clr ? 3'b000 : acc_flags_reg;
    if (push) begin
      acc_flags_next = acc_flags_next | in_status[2:0];
    end

    lost_next = (flags_clr ? 1'b0 : lost_reg) | drop;

    drop_cnt_next = drop_cnt_reg;
    if (drop && (drop_cnt_reg != CNT_MAX)) begin
      drop_cnt_next = drop_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      acc_flags_reg <= '0;
      lost_reg      <= 1'b0;
      drop_cnt_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      level_reg     <= level_next;
      acc_flags_reg <= acc_flags_next;
      lost_reg      <= lost_next;
      drop_cnt_reg  <= drop_cnt_next;
    end
  end

`ifdef FPU_RESBUF_STATS_EN
  logic [15:0] ovf_cnt_reg, unf_cnt_reg;

  assign ovf_cnt = ovf_cnt_reg;
  assign unf_cnt = unf_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_reg <= '0;
      unf_cnt_reg <= '0;
    end else if (push) begin
      if (in_status[2] && (ovf_cnt_reg != 16'hFFFF)) begin
        ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
      end
      if (in_status[1] && (unf_cnt_reg != 16'hFFFF)) begin
        unf_cnt_reg <= unf_cnt_reg + 16'd1;
      end
    end
  end
`endif

endmodule
